// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: SEG-bit carry-select segments, a register stage every
// SPS segments, valid/ready handshake with a single global advance signal stalling the whole pipe.
module csel_adder_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4,
  parameter int unsigned SPS   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NSEG   = WIDTH / SEG;
  localparam int unsigned NSTAGE = NSEG / SPS;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $fatal(1, "csel_adder_pipe: WIDTH must be a multiple of SEG");
  end
  if (NSEG % SPS != 0) begin : g_bad_sps
    $fatal(1, "csel_adder_pipe: WIDTH/SEG must be a multiple of SPS");
  end

  // Operands travel with the partial result; a and b hold B already inverted for subtract.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } stage_t;

  stage_t [NSTAGE-1:0] st_q, st_d;
  stage_t              st_in;
  logic                ovf_q, ovf_d;
  logic                adv;

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  endfunction

  // Resolve the SPS segments owned by stage k: both carry hypotheses per segment, then select.
  function automatic stage_t resolve(input stage_t in, input int unsigned k);
    stage_t         o;
    logic [SEG:0]   p0;
    logic [SEG:0]   p1;
    int unsigned    base;
    o = in;
    for (int unsigned j = 0; j < SPS; j++) begin
      base = (k * SPS + j) * SEG;
      p0 = seg_add(in.a[base +: SEG], in.b[base +: SEG], 1'b0);
      p1 = seg_add(in.a[base +: SEG], in.b[base +: SEG], 1'b1);
      o.s[base +: SEG] = o.c ? p1[SEG-1:0] : p0[SEG-1:0];
      o.c              = o.c ? p1[SEG] : p0[SEG];
    end
    return o;
  endfunction

  assign adv      = !st_q[NSTAGE-1].vld || out_ready;
  assign in_ready = adv && rst_n;

  always_comb begin
    st_in.vld = in_valid && in_ready;
    st_in.a   = in_a;
    st_in.b   = in_sub ? ~in_b : in_b;
    st_in.s   = '0;
    st_in.c   = in_sub | in_cin;
  end

  always_comb begin
    st_d  = st_q;
    ovf_d = ovf_q;
    if (adv) begin
      st_d[0] = resolve(st_in, 0);
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        st_d[k] = resolve(st_q[k-1], k);
      end
      // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
      ovf_d = st_d[NSTAGE-1].a[WIDTH-1] ^ st_d[NSTAGE-1].b[WIDTH-1] ^
              st_d[NSTAGE-1].s[WIDTH-1] ^ st_d[NSTAGE-1].c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = st_q[NSTAGE-1].vld;
  assign out_sum   = st_q[NSTAGE-1].s;
  assign out_cout  = st_q[NSTAGE-1].c;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed self-checking bench for csel_adder_pipe at the default 16/4/1 configuration.
module tb_csel_adder_pipe;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, in_cin, in_sub;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] in_a, in_b, out_sum;
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .SEG(4), .SPS(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Returns {ovf, cout, sum}; overflow from operand/result sign agreement.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         ovf;
    bb  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
    ovf = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t};
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic send_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input logic sub, output logic [W+1:0] res, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    drive_op(a, b, cin, sub);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = {out_ovf, out_cout, out_sum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 16'h0000) begin n_fail++; $display("FAIL rst_sum: got %h want 0000", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b want 0", out_cout); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", out_ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [W+1:0] r;
    int           lat;
    send_and_wait(16'h1234, 16'h4321, 1'b0, 1'b0, r, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
    n_checks++; if (r !== {1'b0, 1'b0, 16'h5555}) begin n_fail++; $display("FAIL basic_result: got %h want %h", r, {1'b0, 1'b0, 16'h5555}); end
  endtask

  task automatic test_wrap();
    logic [W+1:0] r;
    int           lat;
    logic [W-1:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h0FFF};
    logic [W-1:0] tb [3] = '{16'h0001, 16'h0001, 16'h0000};
    logic         tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W+1:0] te [3] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'h1000}};
    for (int i = 0; i < 3; i++) begin
      send_and_wait(ta[i], tb[i], tc[i], 1'b0, r, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wrap_latency[%0d]: got %0d want 4", i, lat); end
      n_checks++; if (r !== te[i]) begin n_fail++; $display("FAIL wrap_result[%0d]: got %h want %h", i, r, te[i]); end
    end
  endtask

  task automatic test_sub();
    logic [W+1:0] r;
    int           lat;
    for (int ci = 0; ci < 2; ci++) begin
      send_and_wait(16'h0005, 16'h0007, 1'(ci), 1'b1, r, lat);
      n_checks++; if (r !== {1'b0, 1'b0, 16'hFFFE}) begin n_fail++; $display("FAIL sub_5_7[cin=%0d]: got %h want %h", ci, r, {1'b0, 1'b0, 16'hFFFE}); end
      send_and_wait(16'h8000, 16'h0001, 1'(ci), 1'b1, r, lat);
      n_checks++; if (r !== {1'b1, 1'b1, 16'h7FFF}) begin n_fail++; $display("FAIL sub_8000_1[cin=%0d]: got %h want %h", ci, r, {1'b1, 1'b1, 16'h7FFF}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp_q [$];
    logic [W+1:0] e;
    logic [W-1:0] a, b;
    logic         ci, sb;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (cyc >= 4 && cyc < 12)) begin
        n_fail++; $display("FAIL b2b_valid[cyc %0d]: got %b want %b", cyc, out_valid, (cyc >= 4 && cyc < 12));
      end
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_cout, out_sum} !== e) begin
          n_fail++; $display("FAIL b2b_result[cyc %0d]: got %h want %h", cyc, {out_ovf, out_cout, out_sum}, e);
        end
      end
      if (cyc < 8) begin
        a = 16'($urandom); b = 16'($urandom);
        ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
        drive_op(a, b, ci, sb);
        exp_q.push_back(ref_model(a, b, ci, sb));
      end else begin
        in_valid = 1'b0;
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [W+1:0] exp_q [$];
    logic [W+1:0] e;
    logic [W-1:0] ta [5] = '{16'h0001, 16'h1111, 16'hFFF0, 16'h8000, 16'h4000};
    logic [W-1:0] tb [5] = '{16'h0002, 16'h2222, 16'h0020, 16'h8000, 16'h4000};
    logic         ts [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int           got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_op(ta[i], tb[i], 1'b0, ts[i]);
      exp_q.push_back(ref_model(ta[i], tb[i], 1'b0, ts[i]));
    end
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(ta[4], tb[4], 1'b0, ts[4]);
    exp_q.push_back(ref_model(ta[4], tb[4], 1'b0, ts[4]));
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", s, in_ready); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", s, out_valid); end
      n_checks++;
      if ({out_ovf, out_cout, out_sum} !== exp_q[0]) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %h want %h", s, {out_ovf, out_cout, out_sum}, exp_q[0]);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 1) in_valid = 1'b0;
      n_checks++;
      if (out_valid !== (cyc < 5)) begin
        n_fail++; $display("FAIL bp_drain_valid[cyc %0d]: got %b want %b", cyc, out_valid, (cyc < 5));
      end
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got++;
        n_checks++;
        if ({out_ovf, out_cout, out_sum} !== e) begin
          n_fail++; $display("FAIL bp_drain_result[%0d]: got %h want %h", got, {out_ovf, out_cout, out_sum}, e);
        end
      end
    end
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", got); end
  endtask

  task automatic test_reset_mid();
    logic [W+1:0] r;
    int           lat;
    logic         stale = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(16'h0100 * 16'(i + 1), 16'h0003, 1'b0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale: got %b want 0", stale); end
    send_and_wait(16'h0F0F, 16'h00F1, 1'b1, 1'b0, r, lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL mid_rst_latency: got %0d want 4", lat); end
    n_checks++; if (r !== {1'b0, 1'b0, 16'h1001}) begin n_fail++; $display("FAIL mid_rst_result: got %h want %h", r, {1'b0, 1'b0, 16'h1001}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor.
- Successor to the single-segment 4-bit carry-select adder: WIDTH bits split into SEG-bit segments, each computing sum for carry-in 0 and 1 in parallel, with the carry selecting the result.
- Pipeline registers are placed after every SPS segments, with a valid/ready handshake and full-pipeline stall.
- Used as the wide integer add/sub unit on datapaths that need throughput of one result per cycle.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, segment width in bits; each segment is one carry-select pair.
- SPS, 1, segments per pipeline stage; NSEG=WIDTH/SEG must be a multiple of SPS; NSTAGE=NSEG/SPS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  operand A (two's complement or unsigned).
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  1: A-B (B inverted, carry-in forced 1); 0: A+B+cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  carry out of MSB. For subtract this is 1 when there is no borrow (A>=B unsigned).
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a rising edge): every stage valid bit, out_valid, out_sum, out_cout and out_ovf are cleared to 0. Partially computed stage data is discarded; in-flight operations are lost, not completed.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational); in_ready is 0 while rst_n=0.
- Accept: on an edge with in_valid && in_ready, the operands enter stage 1.
- Pipeline movement:
  - When adv=1, every stage shifts by one at each edge. The stage-1 valid bit loads in_valid && in_ready.
  - When adv=0, all stage registers hold. No bubble collapsing.
- Stage k (1..NSTAGE) resolves segments (k-1)*SPS .. k*SPS-1:
  - Each segment computes sum0/cout0 (carry-in 0) and sum1/cout1 (carry-in 1).
  - The incoming carry selects between them and ripples across the SPS segments.
  - Carry-out of the stage and the unresolved upper operand bits are registered alongside the low result bits.
  - Effective carry-in for segment 0: in_sub ? 1 : in_cin. B is inverted when in_sub=1.
- Latency:
  - An operand accepted at edge t appears on out_* (out_valid=1) after edge t+NSTAGE-1.
  - Defaults (NSTAGE=4): visible after 4 edges including the accept edge.
  - The last stage register is the output register.
- Throughput: one result per cycle when out_ready is held 1.
- Output hold: while out_valid=1 and out_ready=0, out_sum, out_cout and out_ovf are stable. Nothing is overwritten or dropped.
- Simultaneous events:
  - If out_valid && out_ready and in_valid on the same edge, the output retires and a new input is accepted.
  - Data with stage valid=0 is don't-care but must not raise out_valid.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Wrap example: 0xFFFF+1 gives sum 0x0000, cout=1.
  - Output is bit-identical to a behavioural (A + (sub?~B:B) + cin) of WIDTH+1 bits, with ovf computed as specified.
- Elaboration check: a WIDTH%SEG or NSEG%SPS violation is a fatal elaboration error.

Test Plan:
- Reset, then in_valid=1, a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> after 4 edges out_valid=1, out_sum=0x5555, cout=0, ovf=0. Before that, out_valid=0.
- a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1. In both, cin is ignored (drive 0 and 1).
- Back-to-back stream of 8 random pairs with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching the reference model.
- Backpressure with 4 operations in flight:
  - out_ready=0 for 5 cycles -> in_ready=0 throughout and outputs stable.
  - Release -> all 4 results emerge in order with no loss or duplication.
- Reset mid-stream: 3 operations in flight, rst_n=0 for one edge -> out_valid=0 and all stages empty. No stale result appears afterwards. The first post-reset operand returns after 4 edges.
